// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (IF/ID/EX/MEM/WB); stalls IF, MR and MW until MIO_ready.
// 3-5 cycles per instruction; `define BUS_TIMEOUT_EN sends a stalled bus access to ERR after TIMEOUT_CYC waits.
module mcpu_ctrl_fsm #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       MIO_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemRW,
  output logic       RegWrite,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [3:0] ALU_Control,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [2:0] ImmSel,
  output logic [3:0] state,
  output logic       illegal_inst
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXI = 4'd3, S_MA = 4'd4, S_MR = 4'd5,
    S_MW = 4'd6, S_WBR = 4'd7, S_WBL = 4'd8, S_BR = 4'd9, S_JAL = 4'd10,
    S_JALR = 4'd11, S_LUI = 4'd12, S_ERR = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                         ALU_SLTU = 4'b1001, ALU_XOR = 4'b1100, ALU_OR = 4'b0001,
                         ALU_AND = 4'b0000, ALU_SLL = 4'b1110, ALU_SRL = 4'b1101,
                         ALU_SRA = 4'b1111;
  localparam int W_UNUSED_PARAMS = TIMEOUT_CYC + TO_W;

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec;
  logic       r_ill;
  logic [4:0] w_op;
  logic       w_unused;

  assign w_op     = OPcode[6:2];
  assign w_unused = ^OPcode[1:0];
  assign w_dec    = rst ? S_IF : r_state;
  assign state    = r_state;
  assign illegal_inst = r_ill;

  // Immediate ops never subtract, so SUB needs the register form.
  function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic f7, input logic sub_ok);
    logic [3:0] v;
    case (f3)
      3'b000:  v = (sub_ok && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  v = ALU_SLL;
      3'b010:  v = ALU_SLT;
      3'b011:  v = ALU_SLTU;
      3'b100:  v = ALU_XOR;
      3'b101:  v = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  v = ALU_OR;
      default: v = ALU_AND;
    endcase
    return v;
  endfunction

`ifdef BUS_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            w_wait;
  assign w_wait = ~MIO_ready & ((r_state == S_IF) | (r_state == S_MR) | (r_state == S_MW));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF: if (MIO_ready) w_next = S_ID;
      S_ID: begin
        case (w_op)
          5'b01100:          w_next = S_EXR;
          5'b00100:          w_next = S_EXI;
          5'b00000, 5'b01000: w_next = S_MA;
          5'b11000:          w_next = S_BR;
          5'b11011:          w_next = S_JAL;
          5'b11001:          w_next = S_JALR;
          5'b01101:          w_next = S_LUI;
          default:           w_next = S_ERR;
        endcase
      end
      S_EXR, S_EXI: w_next = S_WBR;
      S_MA: w_next = w_op[3] ? S_MW : S_MR;
      S_MR: if (MIO_ready) w_next = S_WBL;
      S_MW: if (MIO_ready) w_next = S_IF;
      S_WBR, S_WBL, S_BR, S_JAL, S_JALR, S_LUI: w_next = S_IF;
      default: w_next = S_ERR;
    endcase
`ifdef BUS_TIMEOUT_EN
    if (w_wait && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1))) w_next = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERR) r_ill <= 1'b1;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) r_to_cnt <= '0;
    else if (w_wait)                r_to_cnt <= r_to_cnt + 1'b1;
  end
`endif

  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemRW = 1'b0;
    RegWrite = 1'b0; ALUSrc_A = 2'b00; ALUSrc_B = 2'b00; ALU_Control = ALU_AND;
    MemtoReg = 2'b00; PCSource = 2'b00; ImmSel = 3'b000;
    case (w_dec)
      S_IF: begin
        MemRead = 1'b1; ALUSrc_B = 2'b10; ALU_Control = ALU_ADD;
        IRWrite = MIO_ready; PCWrite = MIO_ready;
      end
      S_ID: begin
        ALUSrc_A = 2'b10; ALUSrc_B = 2'b01; ALU_Control = ALU_ADD;
        case (w_op)
          5'b11000:                    ImmSel = 3'b011;
          5'b11011:                    ImmSel = 3'b100;
          5'b01000:                    ImmSel = 3'b010;
          5'b00100, 5'b00000, 5'b11001: ImmSel = 3'b001;
          default:                     ImmSel = 3'b000;
        endcase
      end
      S_EXR: begin
        ALUSrc_A = 2'b01; ALU_Control = f_alu(Fun3, Fun7, 1'b1);
      end
      S_EXI: begin
        ALUSrc_A = 2'b01; ALUSrc_B = 2'b01; ImmSel = 3'b001;
        ALU_Control = f_alu(Fun3, Fun7, 1'b0);
      end
      S_MA: begin
        ALUSrc_A = 2'b01; ALUSrc_B = 2'b01; ALU_Control = ALU_ADD;
        ImmSel = w_op[3] ? 3'b010 : 3'b001;
      end
      S_MR: begin MemRead = 1'b1; IorD = 1'b1; end
      S_MW: begin MemRW = 1'b1; IorD = 1'b1; end
      S_WBR: RegWrite = 1'b1;
      S_WBL: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_BR: begin
        ALUSrc_A = 2'b01; ALU_Control = ALU_SUB; PCSource = 2'b01;
        PCWrite = ((Fun3 == 3'b000) & zero) | ((Fun3 == 3'b001) & ~zero);
      end
      S_JAL: begin
        RegWrite = 1'b1; MemtoReg = 2'b10; PCWrite = 1'b1; PCSource = 2'b01;
      end
      S_JALR: begin
        ALUSrc_A = 2'b01; ALUSrc_B = 2'b01; ImmSel = 3'b001; ALU_Control = ALU_ADD;
        PCSource = 2'b10; PCWrite = 1'b1; RegWrite = 1'b1; MemtoReg = 2'b10;
      end
      S_LUI: begin RegWrite = 1'b1; MemtoReg = 2'b11; end
      default: ;
    endcase
    if (rst) begin
      PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemRW = 1'b0; RegWrite = 1'b0;
    end
  end

endmodule

// File: doc/mcpu_ctrl_fsm.md
Name: mcpu_ctrl_fsm

Overview:
Multi-cycle RV32I control sequencer. Replaces the single-cycle decoder when the core moves to a shared instruction/data memory port. Steps each instruction through IF/ID/EX/MEM/WB states, stalling on MIO_ready. Drives datapath muxes, write enables and the 4-bit ALU_Control code per state.

Parameters:
TIMEOUT_CYC, 255, wait-state cycles before bus timeout (used only with the optional feature)
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
OPcode  in  7  IR[6:0]
Fun3  in  3  IR[14:12]
Fun7  in  1  IR[30]
MIO_ready  in  1  memory/IO transfer done this cycle
zero  in  1  ALU zero flag (valid in BR state)
PCWrite  out  1  PC register load
IRWrite  out  1  IR load
IorD  out  1  memory address source: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemRW  out  1  memory write request
RegWrite  out  1  register file write
ALUSrc_A  out  2  00=PC, 01=rs1, 10=OldPC, 11=zero
ALUSrc_B  out  2  00=rs2, 01=imm, 10=const 4
ALU_Control  out  4  ALU operation code
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC (link), 11=imm
PCSource  out  2  00=ALU result, 01=ALUOut, 10=ALU result with bit0 cleared
ImmSel  out  3  000=U, 001=I, 010=S, 011=B, 100=J
state  out  4  current state, for debug/VGA
illegal_inst  out  1  sticky, set in ERR

Behaviour:
- State register, encoding: IF=0, ID=1, EXR=2, EXI=3, MA=4, MR=5, MW=6, WBR=7, WBL=8, BR=9, JAL=10, JALR=11, LUI=12, ERR=15.
- rst: state<=IF, illegal_inst<=0. While rst=1, all enables (PCWrite, IRWrite, MemRead, MemRW, RegWrite) are forced to 0. Mux outputs equal the IF decode.
- Unlisted outputs in a state are 0. ALU codes: ADD=0010, SUB=0110, SLT=0111, SLTU=1001, XOR=1100, OR=0001, AND=0000, SLL=1110, SRL=1101, SRA=1111.
- IF:
  - MemRead=1, IorD=0, ALUSrc_A=00, ALUSrc_B=10, ALU ADD, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle MIO_ready=1; the FSM then moves to ID. Otherwise it holds in IF.
- ID:
  - ALUSrc_A=10, ALUSrc_B=01, ALU ADD, ImmSel per opcode; the branch/jump target is latched in ALUOut.
  - Next state by OPcode[6:2]: 01100->EXR, 00100->EXI, 00000/01000->MA, 11000->BR, 11011->JAL, 11001->JALR, 01101->LUI.
  - Any other opcode -> ERR.
- EXR: ALUSrc_A=01, ALUSrc_B=00. {Fun3,Fun7} selects ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. Next state WBR.
- EXI: ALUSrc_B=01, ImmSel=001. Fun3 selects the op; Fun3=101 uses Fun7 (SRA vs SRL); SUB is never produced. Next state WBR.
- MA: rs1+imm computed with ALU ADD. ImmSel=001 for loads, 010 for stores. Next state MR (load) or MW (store).
- MR: MemRead=1, IorD=1. Holds until MIO_ready, then WBL.
- MW: MemRW=1, IorD=1. Holds until MIO_ready, then IF.
- WBR: RegWrite=1, MemtoReg=00, then IF.
- WBL: RegWrite=1, MemtoReg=01, then IF.
- BR:
  - ALU SUB on rs1,rs2; PCSource=01.
  - PCWrite = (Fun3==000 & zero) | (Fun3==001 & ~zero). Other Fun3 values do not write.
  - Next state IF.
- JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01, then IF.
- JALR: ALUSrc_A=01, ALUSrc_B=01, ImmSel=001, ALU ADD, PCSource=10, PCWrite=1, RegWrite=1, MemtoReg=10, then IF.
- LUI: RegWrite=1, MemtoReg=11, ImmSel=000, then IF.
- ERR: all enables 0, illegal_inst=1. Left only by rst.
- Latency with MIO_ready held at 1: R/I/LUI/JAL/JALR/store = 4 or 3 cycles as sequenced above; load = 5; branch = 3.
- rst asserted mid-instruction aborts it: no further enables fire, and the FSM is in IF on the next cycle.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined: a TO_W-bit counter clears on every state change and increments each cycle spent in IF, MR or MW with MIO_ready=0. When it reaches TIMEOUT_CYC, the next state is ERR and illegal_inst=1.
- Undefined: the counter is absent and the FSM waits indefinitely.

Test Plan:
- add x3,x1,x2 (0x002081B3), MIO_ready=1 -> states 0,1,2,7,0; ALU_Control=0010 in EXR; RegWrite=1 only in WBR.
- lw (0x0000A183), MIO_ready low for 3 cycles in MR -> MR held 4 cycles, MemRead=1, IorD=1 throughout; WBL RegWrite=1, MemtoReg=01.
- beq with zero=1, then bne with zero=1 -> PCWrite=1 in BR for beq, 0 for bne; PCSource=01.
- srai (Fun3=101, Fun7=1, OPcode=0010011) -> ALU_Control=1111; srli (Fun7=0) -> 1101.
- OPcode=0x7F -> ERR, illegal_inst=1 and held; rst pulse -> state=0, illegal_inst=0.
- BUS_TIMEOUT_EN defined, TIMEOUT_CYC=255, MIO_ready=0 in IF -> ERR entered after 255 wait cycles; IRWrite never asserted.
